// File: rtl/pmem_burst_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory burst arbiter.
// A cache line travels as BURST_BEATS beats on the memory port.
package pmem_burst_arbiter_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int BURST_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_IDX_W  = $clog2(BURST_BEATS);

  typedef logic [LINE_WIDTH-1:0] cacheline_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
  typedef logic [31:0]           paddr_t;

  typedef enum logic [2:0] {
    IDLE,
    BURST_I,
    BURST_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Beat k of a line occupies bits [64k+63:64k].
  function automatic beat_t line_beat(input cacheline_t line, input beat_idx_t idx);
    return line[BEAT_WIDTH*int'(idx) +: BEAT_WIDTH];
  endfunction

endpackage

// File: rtl/pmem_burst_arbiter_if.sv
// Bundles the icache, dcache and memory-side pmem ports of the arbiter.
// The slave view is the arbiter itself; the master view is its environment.
interface pmem_burst_arbiter_if;
  import pmem_burst_arbiter_pkg::*;

  // icache side (read only)
  logic       pmem_read_c_i;
  paddr_t     pmem_address_c_i;
  cacheline_t pmem_rdata_c_i;
  logic       pmem_resp_c_i;

  // dcache side
  logic       pmem_read_c_d;
  logic       pmem_write_c_d;
  paddr_t     pmem_address_c_d;
  cacheline_t pmem_wdata_c_d;
  cacheline_t pmem_rdata_c_d;
  logic       pmem_resp_c_d;

  // physical memory burst port
  logic       pmem_read_m;
  logic       pmem_write_m;
  paddr_t     pmem_address_m;
  beat_t      pmem_wdata_m;
  beat_t      pmem_rdata_m;
  logic       pmem_resp_m;

  modport slave (
    input  pmem_read_c_i, pmem_address_c_i,
    output pmem_rdata_c_i, pmem_resp_c_i,
    input  pmem_read_c_d, pmem_write_c_d, pmem_address_c_d, pmem_wdata_c_d,
    output pmem_rdata_c_d, pmem_resp_c_d,
    output pmem_read_m, pmem_write_m, pmem_address_m, pmem_wdata_m,
    input  pmem_rdata_m, pmem_resp_m
  );

  modport master (
    output pmem_read_c_i, pmem_address_c_i,
    input  pmem_rdata_c_i, pmem_resp_c_i,
    output pmem_read_c_d, pmem_write_c_d, pmem_address_c_d, pmem_wdata_c_d,
    input  pmem_rdata_c_d, pmem_resp_c_d,
    input  pmem_read_m, pmem_write_m, pmem_address_m, pmem_wdata_m,
    output pmem_rdata_m, pmem_resp_m
  );

endinterface

// File: rtl/pmem_burst_arbiter_line_buffer.sv
// 256-bit line buffer with a beat index: parallel load for writebacks,
// beat-wise assembly for reads and a beat read mux for write serialization.
module pmem_line_buffer
  import pmem_burst_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  cacheline_t load_line,
  input  logic       beat_en,
  input  logic       beat_store,
  input  beat_t      beat_in,
  output cacheline_t line,
  output beat_t      beat_out,
  output logic       last_beat
);

  beat_idx_t idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the line register is reset on purpose; it drives both cache
      // rdata ports and the write beat, all of which must read 0 after reset.
      line <= '0;
      idx  <= '0;
    end else begin
      if (load) begin
        line <= load_line;
      end
      if (clear) begin
        idx <= '0;
      end else if (beat_en) begin
        if (beat_store) begin
          line[BEAT_WIDTH*int'(idx) +: BEAT_WIDTH] <= beat_in;
        end
        idx <= idx + beat_idx_t'(1);
      end
    end
  end

  assign beat_out  = line_beat(line, idx);
  assign last_beat = (idx == beat_idx_t'(BURST_BEATS - 1));

endmodule

// File: rtl/pmem_burst_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst memory port between the
// icache and dcache; each grant moves one 256-bit line as a 4-beat burst.
module pmem_burst_arbiter
  import pmem_burst_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  pmem_burst_arbiter_if.slave bus
);

  arb_state_t state;
  grant_t     last_grant;
  paddr_t     addr_q;
  logic       read_cmd;
  logic       write_cmd;
  logic       resp_i;
  logic       resp_d;

  logic       req_i;
  logic       req_d;
  logic       grant_d;
  logic       grant_wr;
  logic       start;
  logic       in_burst;
  logic       last_beat;
  cacheline_t line;
  beat_t      beat_out;

  assign req_i = bus.pmem_read_c_i;
  assign req_d = bus.pmem_read_c_d | bus.pmem_write_c_d;

  // On a tie the cache that was not served last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_d = 1'b0;
    if (req_d && (!req_i || last_grant == GRANT_I)) begin
      grant_d = 1'b1;
    end
  end

  // A dcache request with the write strobe up is a write, even if read is also set.
  assign grant_wr = grant_d & bus.pmem_write_c_d;
  assign start    = (state == IDLE) && (req_i || req_d);
  assign in_burst = (state == BURST_I) || (state == BURST_D);

  pmem_line_buffer u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .load       (start && grant_wr),
    .load_line  (bus.pmem_wdata_c_d),
    .beat_en    (in_burst && bus.pmem_resp_m),
    .beat_store (read_cmd),
    .beat_in    (bus.pmem_rdata_m),
    .line       (line),
    .beat_out   (beat_out),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      read_cmd   <= 1'b0;
      write_cmd  <= 1'b0;
      resp_i     <= 1'b0;
      resp_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values regardless of statement order.
      resp_i <= 1'b0;
      resp_d <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            state     <= grant_d ? BURST_D : BURST_I;
            addr_q    <= grant_d ? bus.pmem_address_c_d : bus.pmem_address_c_i;
            read_cmd  <= ~grant_wr;
            write_cmd <= grant_wr;
          end
        end
        BURST_I, BURST_D: begin
          if (bus.pmem_resp_m && last_beat) begin
            state     <= (state == BURST_I) ? DONE_I : DONE_D;
            read_cmd  <= 1'b0;
            write_cmd <= 1'b0;
            resp_i    <= (state == BURST_I);
            resp_d    <= (state == BURST_D);
          end
        end
        // Always back to IDLE so a request still high here is not re-granted.
        DONE_I: begin
          state      <= IDLE;
          last_grant <= GRANT_I;
        end
        DONE_D: begin
          state      <= IDLE;
          last_grant <= GRANT_D;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read_m    = read_cmd;
  assign bus.pmem_write_m   = write_cmd;
  assign bus.pmem_address_m = addr_q;
  assign bus.pmem_wdata_m   = beat_out;
  assign bus.pmem_rdata_c_i = line;
  assign bus.pmem_rdata_c_d = line;
  assign bus.pmem_resp_c_i  = resp_i;
  assign bus.pmem_resp_c_d  = resp_d;

endmodule

// File: tb/tb_pmem_burst_arbiter.sv
// Self-checking bench for pmem_burst_arbiter: directed scenarios followed by
// randomized traffic against a word-level memory model and round-robin rule.
module tb_pmem_burst_arbiter;
  import pmem_burst_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmem_burst_arbiter_if bus ();

  pmem_burst_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Memory model: one 64-bit word per beat address.
  beat_t mem [paddr_t];
  bit    last_d = 1'b0;

  task automatic check(input string tag, input cacheline_t obs, input cacheline_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mem_rd(input paddr_t a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  function automatic cacheline_t model_line(input paddr_t a);
    cacheline_t l;
    for (int k = 0; k < BURST_BEATS; k++) l[64*k +: 64] = mem_rd(a + paddr_t'(8*k));
    return l;
  endfunction

  function automatic cacheline_t rand_line();
    cacheline_t l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_read_m"},  bus.pmem_read_m, 0);
    check({tag, "_write_m"}, bus.pmem_write_m, 0);
    check({tag, "_addr_m"},  bus.pmem_address_m, 0);
    check({tag, "_wdata_m"}, bus.pmem_wdata_m, 0);
    check({tag, "_resp_c"},  {bus.pmem_resp_c_i, bus.pmem_resp_c_d}, 0);
    check({tag, "_rdata_i"}, bus.pmem_rdata_c_i, 0);
    check({tag, "_rdata_d"}, bus.pmem_rdata_c_d, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    last_d = 1'b0;
  endtask

  // Called at the negedge after requests change; returns at the DONE negedge
  // (or after nb beats when nb < BURST_BEATS). gap < 0 picks 0..3 idle cycles.
  task automatic run_burst(input string tag, input bit exp_d, input bit exp_wr,
                           input paddr_t addr, input cacheline_t wline,
                           input int gap, input int nb);
    int n;
    int g;
    paddr_t a;
    @(negedge clk);
    n = 1;
    while (!(bus.pmem_read_m || bus.pmem_write_m) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_seen"}, bus.pmem_read_m | bus.pmem_write_m, 1);
    if (!(bus.pmem_read_m || bus.pmem_write_m)) return;
    check({tag, "_latency"}, n, 1);
    check({tag, "_dir"}, {bus.pmem_read_m, bus.pmem_write_m}, {!exp_wr, exp_wr});
    for (int k = 0; k < nb; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      a = addr + paddr_t'(8*k);
      for (int j = 0; j <= g; j++) begin
        check({tag, "_hold"},
              {bus.pmem_read_m | bus.pmem_write_m, bus.pmem_address_m,
               bus.pmem_resp_c_i, bus.pmem_resp_c_d},
              {1'b1, addr, 2'b00});
        if (exp_wr) check({tag, "_wdata"}, bus.pmem_wdata_m, wline[64*k +: 64]);
        if (j < g) @(negedge clk);
      end
      if (exp_wr) mem[a] = bus.pmem_wdata_m;
      else bus.pmem_rdata_m = mem_rd(a);
      bus.pmem_resp_m = 1'b1;
      @(negedge clk);
      bus.pmem_resp_m  = 1'b0;
      bus.pmem_rdata_m = {$urandom, $urandom};
    end
    if (nb < BURST_BEATS) return;
    check({tag, "_cmd_off"}, {bus.pmem_read_m, bus.pmem_write_m}, 0);
    check({tag, "_resp"}, {bus.pmem_resp_c_i, bus.pmem_resp_c_d}, exp_d ? 2'b01 : 2'b10);
    if (exp_wr) begin
      check({tag, "_rdata_d"}, bus.pmem_rdata_c_d, wline);
    end else begin
      check({tag, "_rdata_i"}, bus.pmem_rdata_c_i, model_line(addr));
      check({tag, "_rdata_d"}, bus.pmem_rdata_c_d, model_line(addr));
    end
    last_d = exp_d;
  endtask

  // The cycle after DONE is IDLE: no command and no completion pulse.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle"},
          {bus.pmem_read_m, bus.pmem_write_m, bus.pmem_resp_c_i, bus.pmem_resp_c_d}, 0);
  endtask

  initial begin
    cacheline_t wl;
    cacheline_t exp_line;
    bit ri, rd, dwr, first_d;
    paddr_t ai, ad;

    bus.pmem_read_c_i    = 1'b0;
    bus.pmem_address_c_i = '0;
    bus.pmem_read_c_d    = 1'b0;
    bus.pmem_write_c_d   = 1'b0;
    bus.pmem_address_c_d = '0;
    bus.pmem_wdata_c_d   = '0;
    bus.pmem_rdata_m     = '0;
    bus.pmem_resp_m      = 1'b0;
    do_reset();

    // icache line read with fixed beat data
    mem[32'h40] = 64'h1111_1111_1111_1111;
    mem[32'h48] = 64'h2222_2222_2222_2222;
    mem[32'h50] = 64'h3333_3333_3333_3333;
    mem[32'h58] = 64'h4444_4444_4444_4444;
    bus.pmem_read_c_i = 1'b1;
    bus.pmem_address_c_i = 32'h40;
    run_burst("ic_rd", 1'b0, 1'b0, 32'h40, '0, 0, 4);
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    check("ic_rd_line", bus.pmem_rdata_c_i, exp_line);
    bus.pmem_read_c_i = 1'b0;
    idle_check("ic_rd");
    check("ic_rd_line_stable", bus.pmem_rdata_c_i, exp_line);

    // dcache writeback, beats go out D, C, B, A
    wl = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
    bus.pmem_write_c_d = 1'b1;
    bus.pmem_address_c_d = 32'h100;
    bus.pmem_wdata_c_d = wl;
    run_burst("dc_wr", 1'b1, 1'b1, 32'h100, wl, 0, 4);
    bus.pmem_write_c_d = 1'b0;
    idle_check("dc_wr");
    check("dc_wr_beat0", mem[32'h100], {16{4'hD}});
    check("dc_wr_beat3", mem[32'h118], {16{4'hA}});

    // tie from reset: dcache, icache, dcache
    do_reset();
    bus.pmem_read_c_i = 1'b1;
    bus.pmem_address_c_i = 32'h200;
    bus.pmem_read_c_d = 1'b1;
    bus.pmem_address_c_d = 32'h300;
    run_burst("tie_1d", 1'b1, 1'b0, 32'h300, '0, 1, 4);
    bus.pmem_read_c_d = 1'b0;
    idle_check("tie_1d");
    bus.pmem_read_c_d = 1'b1;
    bus.pmem_address_c_d = 32'h320;
    run_burst("tie_2i", 1'b0, 1'b0, 32'h200, '0, 0, 4);
    bus.pmem_read_c_i = 1'b0;
    idle_check("tie_2i");
    run_burst("tie_3d", 1'b1, 1'b0, 32'h320, '0, 2, 4);
    bus.pmem_read_c_d = 1'b0;
    idle_check("tie_3d");

    // non-consecutive beats
    bus.pmem_read_c_i = 1'b1;
    bus.pmem_address_c_i = 32'h400;
    run_burst("gap3", 1'b0, 1'b0, 32'h400, '0, 3, 4);
    bus.pmem_read_c_i = 1'b0;
    idle_check("gap3");
    bus.pmem_read_c_d = 1'b1;
    bus.pmem_address_c_d = 32'h420;
    run_burst("gap_rand", 1'b1, 1'b0, 32'h420, '0, -1, 4);
    bus.pmem_read_c_d = 1'b0;
    idle_check("gap_rand");

    // reset after two beats, then the held request completes in full
    bus.pmem_read_c_i = 1'b1;
    bus.pmem_address_c_i = 32'h500;
    run_burst("rst_mid", 1'b0, 1'b0, 32'h500, '0, 0, 2);
    do_reset();
    run_burst("rst_retry", 1'b0, 1'b0, 32'h500, '0, 1, 4);
    bus.pmem_read_c_i = 1'b0;
    idle_check("rst_retry");

    // stray memory response in IDLE is ignored
    bus.pmem_resp_m = 1'b1;
    @(negedge clk);
    bus.pmem_resp_m = 1'b0;
    @(negedge clk);
    check("stray_resp", {bus.pmem_read_m, bus.pmem_write_m,
                         bus.pmem_resp_c_i, bus.pmem_resp_c_d}, 0);
    bus.pmem_read_c_i = 1'b1;
    bus.pmem_address_c_i = 32'h600;
    run_burst("stray_rd", 1'b0, 1'b0, 32'h600, '0, 0, 4);
    bus.pmem_read_c_i = 1'b0;
    idle_check("stray_rd");

    // dcache read and write together act as a write
    wl = rand_line();
    bus.pmem_read_c_d = 1'b1;
    bus.pmem_write_c_d = 1'b1;
    bus.pmem_address_c_d = 32'h700;
    bus.pmem_wdata_c_d = wl;
    run_burst("rw_both", 1'b1, 1'b1, 32'h700, wl, 0, 4);
    bus.pmem_read_c_d = 1'b0;
    bus.pmem_write_c_d = 1'b0;
    idle_check("rw_both");
    bus.pmem_read_c_i = 1'b1;
    bus.pmem_address_c_i = 32'h700;
    run_burst("rw_readback", 1'b0, 1'b0, 32'h700, '0, 0, 4);
    check("rw_readback_line", bus.pmem_rdata_c_i, wl);
    bus.pmem_read_c_i = 1'b0;
    idle_check("rw_readback");

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      ri  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      dwr = 1'($urandom_range(0, 1));
      if (!ri && !rd) ri = 1'b1;
      ai = 32'h800 + paddr_t'(32 * $urandom_range(0, 7));
      ad = 32'h800 + paddr_t'(32 * $urandom_range(0, 7));
      wl = rand_line();
      bus.pmem_read_c_i    = ri;
      bus.pmem_address_c_i = ai;
      bus.pmem_read_c_d    = rd & !dwr;
      bus.pmem_write_c_d   = rd & dwr;
      bus.pmem_address_c_d = ad;
      bus.pmem_wdata_c_d   = wl;
      first_d = (ri && rd) ? !last_d : rd;
      if (first_d) begin
        run_burst("rnd_d", 1'b1, dwr, ad, wl, -1, 4);
        bus.pmem_read_c_d = 1'b0;
        bus.pmem_write_c_d = 1'b0;
      end else begin
        run_burst("rnd_i", 1'b0, 1'b0, ai, '0, -1, 4);
        bus.pmem_read_c_i = 1'b0;
      end
      idle_check("rnd_first");
      if (ri && rd) begin
        if (first_d) begin
          run_burst("rnd_i2", 1'b0, 1'b0, ai, '0, -1, 4);
          bus.pmem_read_c_i = 1'b0;
        end else begin
          run_burst("rnd_d2", 1'b1, dwr, ad, wl, -1, 4);
          bus.pmem_read_c_d = 1'b0;
          bus.pmem_write_c_d = 1'b0;
        end
        idle_check("rnd_second");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pmem_burst_arbiter.md
# pmem_burst_arbiter

Shares the single 64-bit burst physical-memory port between the instruction cache (read-only) and the data cache (read/write) in the mp4 top level. Grants one 256-bit cache-line transaction at a time, round-robin, and converts it to a 4-beat memory burst. Read bursts are assembled into a 256-bit line and write lines are serialized into 64-bit beats. Sits between the two caches' pmem ports and the top-level pmem pins.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BEAT_WIDTH, 64, memory beat width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH = 4
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- pmem_read_c_i  in  1  icache line-read request, held until resp
- pmem_address_c_i  in  32  icache line address (low 5 bits zero)
- pmem_rdata_c_i  out  256  line returned to icache
- pmem_resp_c_i  out  1  one-cycle icache completion pulse
- pmem_read_c_d / pmem_write_c_d  in  1  dcache line read/write request, held until resp
- pmem_address_c_d  in  32  dcache line address
- pmem_wdata_c_d  in  256  dcache writeback line, stable while write held
- pmem_rdata_c_d  out  256  line returned to dcache
- pmem_resp_c_d  out  1  one-cycle dcache completion pulse
- pmem_read_m / pmem_write_m  out  1  memory burst command
- pmem_address_m  out  32  burst line address
- pmem_wdata_m  out  64  current write beat
- pmem_rdata_m  in  64  current read beat
- pmem_resp_m  in  1  one pulse per completed beat

## Operation
- FSM states: IDLE, BURST_I, BURST_D, DONE_I, DONE_D.
- IDLE: if exactly one cache requests, grant it. If both request, grant the one not granted last. last_grant resets to icache, so dcache wins the first tie.
- Grant latches address, direction (dcache write if pmem_write_c_d, else read) and, for writes, pmem_wdata_c_d into the line buffer. Beat counter is cleared.
- Simultaneous pmem_read_c_d and pmem_write_c_d is illegal. The arbiter treats it as a write.
- BURST_x: pmem_read_m or pmem_write_m is held high with pmem_address_m constant.
  - Each pmem_resp_m increments the beat counter. On a read, it stores pmem_rdata_m into line bits [64k+63:64k], where k is the beat index.
  - pmem_wdata_m = line beat k throughout.
  - Beats may be non-consecutive.
  - On the 4th resp (k=3), go to DONE_x. The command is deasserted from that next cycle.
- DONE_x: pmem_resp_c_x = 1 for exactly this cycle. Next state is IDLE unconditionally, so a request still high in DONE is never re-granted. last_grant is updated here.
- pmem_rdata_c_i and pmem_rdata_c_d both drive the line buffer. Each is valid in and after its DONE cycle and stays stable until the next grant.
- pmem_resp_m outside BURST is ignored.
- Reset (rst=0), including mid-burst: next state IDLE, beat counter 0, last_grant=icache. Any partial line is discarded; the cache must re-request.

## Timing
- Reset values: all command, resp and wdata outputs are 0. Address is 0. Line buffer is 0.
- All outputs are registered or Moore-decoded from state. There is no combinational path from cache inputs to memory outputs.
- Request seen in IDLE at cycle N: the memory command is high at N+1.
- 4th pmem_resp_m at cycle M: DONE/resp_c at M+1, IDLE at M+2. The earliest next command is M+3.
- Minimum transaction, with back-to-back beats: 1 + 4 + 1 + 1 = 7 cycles from the request cycle to the next possible grant.
- Requests must stay asserted until the cycle after resp_c. Dropping one early is unsupported.

## Structure
- Add to the shared rv32i_types package:
  - enum arb_state_t {IDLE, BURST_I, BURST_D, DONE_I, DONE_D}
  - localparam BURST_BEATS = 4
  - typedef cacheline_t = logic [255:0]
- One sub-module, pmem_line_buffer. It holds the 256-bit register, a 2-bit beat index, parallel load (write capture), beat write (read assembly) and the beat read mux.
- The arbiter keeps the FSM, last_grant and the latched address/direction.

## Test plan
- icache reads 0x0000_0040 only, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> pmem_read_m high 4 beats at address 0x40, pmem_rdata_c_i = {0x44..,0x33..,0x22..,0x11..}, pmem_resp_c_i pulses once.
- dcache writes line 0xA..A_B..B_C..C_D..D at 0x100 -> pmem_wdata_m = D..D, C..C, B..B, A..A in beat order. pmem_write_m drops after the 4th resp, then pmem_resp_c_d pulses.
- Both request from reset, then both again -> order dcache, icache, dcache. No grant is issued in any DONE cycle.
- Beats with 0–3 idle cycles between pmem_resp_m pulses -> line assembled correctly, address stable, exactly one resp_c.
- rst=0 after 2 beats of an icache read -> IDLE next cycle, all outputs 0. The re-request completes with the full 4 beats.
- pmem_resp_m pulsed in IDLE, and dcache read+write both high -> no state change for the first; the second performs a write.
